// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Purpose  : M-input arbitrating multiplexer with one registered output stage.
//            In MODE 0 a rotating priority pointer gives round-robin fairness.
//            In MODE 1 the lowest-index valid channel always wins.
// Ports    : clk        - single clock, rising edge
//            reset      - synchronous, active-high
//            in_valid   - per-channel valid (M bits)
//            in_data    - channel i data in bits [i*N +: N]
//            in_ready   - one-hot/zero accept strobe (combinational)
//            out_valid  - output register holds a word
//            out_data   - registered data of the granted channel
//            out_sel    - registered index of the channel that supplied data
//            out_ready  - downstream accepts out_data this cycle
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
    parameter  int N    = 64,
    parameter  int M    = 4,
    parameter  int MODE = 0,
    localparam int SW   = $clog2(M)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [M-1:0]     in_valid,
    input  logic [M*N-1:0]   in_data,
    output logic [M-1:0]     in_ready,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    output logic [SW-1:0]    out_sel,
    input  logic             out_ready
);

    // One extra bit so base + offset (at most 2M-2) never overflows before
    // the modulo-M correction.
    localparam logic [SW:0]   C_M    = (SW+1)'(M);
    localparam logic [SW-1:0] C_LAST = SW'(M-1);

    logic            r_out_valid;
    logic [N-1:0]    r_out_data;
    logic [SW-1:0]   r_out_sel;
    logic [SW-1:0]   r_ptr;

    logic            w_load_en;
    logic            w_found;
    logic [SW-1:0]   w_gnt;
    logic [N-1:0]    w_gnt_data;
    logic [SW-1:0]   w_ptr_next;
    logic [M-1:0]    w_ready;

    // The output register may take a new word when empty or being drained.
    assign w_load_en = !r_out_valid || out_ready;

    // Search ptr, ptr+1, ... wrapping modulo M; first valid channel wins.
    // Fixed-priority mode always starts the search at channel 0.
    always_comb begin : grant_search
        logic [SW:0]   v_idx;
        logic [SW-1:0] v_base;
        logic          v_found;
        logic [SW-1:0] v_gnt;
        v_found = 1'b0;
        v_gnt   = '0;
        v_idx   = '0;
        v_base  = (MODE == 1) ? '0 : r_ptr;
        for (int k = 0; k < M; k++) begin
            v_idx = {1'b0, v_base} + (SW+1)'(k);
            if (v_idx >= C_M) begin
                v_idx = v_idx - C_M;
            end
            if (!v_found && in_valid[v_idx[SW-1:0]]) begin
                v_found = 1'b1;
                v_gnt   = v_idx[SW-1:0];
            end
        end
        w_found = v_found;
        w_gnt   = v_gnt;
    end

    // Data mux of the granted channel.
    always_comb begin : data_mux
        w_gnt_data = '0;
        for (int i = 0; i < M; i++) begin
            if (w_gnt == SW'(i)) begin
                w_gnt_data = in_data[i*N +: N];
            end
        end
    end

    // Ready goes only to the granted channel, and only when the output stage
    // can load; forced low during reset so nothing is consumed.
    always_comb begin : ready_gen
        w_ready = '0;
        if (!reset && w_found && w_load_en) begin
            w_ready[w_gnt] = 1'b1;
        end
    end

    // Explicit wrap so non-power-of-two M never lands on index M.
    assign w_ptr_next = (w_gnt == C_LAST) ? '0 : (w_gnt + SW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_found) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_sel   <= w_gnt;
                r_ptr       <= (MODE == 1) ? '0 : w_ptr_next;
            end else begin
                // Nothing to load: drop valid, keep last data/sel visible.
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sel   = r_out_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Purpose  : Self-checking bench for rr_arb_mux. Three instances: round-robin
//            M=4, fixed priority M=4, round-robin M=3. Directed vector table,
//            hand-written sequences and random stimulus against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;

    localparam logic [63:0] C0 = 64'h1111_0000_0000_0000;
    localparam logic [63:0] C1 = 64'h2222_0000_0000_0001;
    localparam logic [63:0] C2 = 64'hDEAD_BEEF_0000_0002;
    localparam logic [63:0] C3 = 64'h4444_0000_0000_0003;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         ordy;

    logic [3:0]   v0, v1;
    logic [255:0] d0, d1;
    logic [3:0]   rdy0, rdy1;
    logic         ov0, ov1;
    logic [63:0]  od0, od1;
    logic [1:0]   os0, os1;

    logic [2:0]   v2;
    logic [191:0] d2;
    logic [2:0]   rdy2;
    logic         ov2;
    logic [63:0]  od2;
    logic [1:0]   os2;

    int vectors    = 0;
    int miscompares = 0;

    rr_arb_mux #(.N(64), .M(4), .MODE(0)) dut0 (
        .clk(clk), .reset(rst), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .out_valid(ov0), .out_data(od0), .out_sel(os0), .out_ready(ordy)
    );

    rr_arb_mux #(.N(64), .M(4), .MODE(1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy)
    );

    rr_arb_mux #(.N(64), .M(3), .MODE(0)) dut2 (
        .clk(clk), .reset(rst), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
        .out_valid(ov2), .out_data(od2), .out_sel(os2), .out_ready(ordy)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic        ordy;
        logic [3:0]  exp_rdy;
        logic        exp_ov;
        logic [63:0] exp_od;
        logic [1:0]  exp_os;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Spec-level grant: scan channels in priority order, first valid wins.
    function automatic int model_grant(input logic [3:0] vld, input int ptr,
                                       input int m, input int mode);
        for (int k = 0; k < m; k++) begin
            int c;
            c = (mode == 1) ? k : (ptr + k) % m;
            if (vld[c]) return c;
        end
        return -1;
    endfunction

    task automatic rand_run(input int which, input int m, input int mode, input int cycles);
        bit          m_ov;
        logic [63:0] m_od;
        int          m_os, m_ptr, g;
        bit          le;
        logic [3:0]  vld, exp_rdy, act_rdy;
        logic [63:0] d [4];
        logic        act_ov;
        logic [63:0] act_od;
        logic [1:0]  act_os;
        m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0;
        for (int n = 0; n < cycles; n++) begin
            rst  = (n == 0) || ($urandom_range(0, 39) == 0);
            ordy = ($urandom_range(0, 3) != 0);
            vld  = 4'($urandom_range(0, 15));
            if (m == 3) vld[3] = 1'b0;
            for (int c = 0; c < 4; c++) d[c] = {$urandom, $urandom};
            case (which)
                0: begin v0 = vld; d0 = {d[3], d[2], d[1], d[0]}; end
                1: begin v1 = vld; d1 = {d[3], d[2], d[1], d[0]}; end
                default: begin v2 = vld[2:0]; d2 = {d[2], d[1], d[0]}; end
            endcase
            g  = model_grant(vld, m_ptr, m, mode);
            le = !m_ov || ordy;
            exp_rdy = (rst || g < 0 || !le) ? 4'b0000 : 4'(1 << g);
            #1;
            case (which)
                0: act_rdy = rdy0;
                1: act_rdy = rdy1;
                default: act_rdy = {1'b0, rdy2};
            endcase
            chk("rand_in_ready", 64'(act_rdy), 64'(exp_rdy));
            if (rst) begin
                m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0;
            end else if (le) begin
                if (g >= 0) begin
                    m_ov  = 1;
                    m_od  = d[g];
                    m_os  = g;
                    m_ptr = (mode == 1) ? 0 : (g + 1) % m;
                end else begin
                    m_ov = 0;
                end
            end
            @(posedge clk);
            @(negedge clk);
            case (which)
                0: begin act_ov = ov0; act_od = od0; act_os = os0; end
                1: begin act_ov = ov1; act_od = od1; act_os = os1; end
                default: begin act_ov = ov2; act_od = od2; act_os = os2; end
            endcase
            chk("rand_out_valid", 64'(act_ov), 64'(m_ov));
            chk("rand_out_data", act_od, m_od);
            chk("rand_out_sel", 64'(act_os), 64'(m_os));
        end
    endtask

    initial begin
        // rst, valid, ordy, exp_rdy, exp_ov, exp_od, exp_os
        tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 1'b0, 64'h0, 2'd0}; // reset
        tbl[1]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, C0,    2'd0}; // rr 0
        tbl[2]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 1'b1, C1,    2'd1};
        tbl[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, C2,    2'd2};
        tbl[4]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 1'b1, C3,    2'd3};
        tbl[5]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, C0,    2'd0}; // wrap
        tbl[6]  = '{1'b0, 4'b0100, 1'b1, 4'b0100, 1'b1, C2,    2'd2}; // only ch2
        tbl[7]  = '{1'b0, 4'b1100, 1'b1, 4'b1000, 1'b1, C3,    2'd3}; // ch3 first
        tbl[8]  = '{1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, C3,    2'd3}; // empty, hold
        tbl[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, C3,    2'd3};
        tbl[10] = '{1'b0, 4'b0010, 1'b1, 4'b0010, 1'b1, C1,    2'd1}; // ptr 0 -> ch1
        tbl[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C1,    2'd1}; // stall x5
        tbl[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C1,    2'd1};
        tbl[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C1,    2'd1};
        tbl[14] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C1,    2'd1};
        tbl[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C1,    2'd1};
        tbl[16] = '{1'b0, 4'b1111, 1'b1, 4'b0100, 1'b1, C2,    2'd2}; // drain+fill
        tbl[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 1'b1, C2,    2'd2}; // stall
        tbl[18] = '{1'b1, 4'b1111, 1'b0, 4'b0000, 1'b0, 64'h0, 2'd0}; // reset mid-stall
        tbl[19] = '{1'b0, 4'b1111, 1'b1, 4'b0001, 1'b1, C0,    2'd0}; // restart at ch0

        rst = 1'b1; ordy = 1'b0;
        v0 = '0; v1 = '0; v2 = '0;
        d0 = {C3, C2, C1, C0};
        d1 = {C3, C2, C1, C0};
        d2 = {C2, C1, C0};
        @(negedge clk);

        // Directed table on round-robin M=4 instance.
        for (int i = 0; i < 20; i++) begin
            rst  = tbl[i].rst;
            v0   = tbl[i].valid;
            ordy = tbl[i].ordy;
            #1;
            chk($sformatf("tbl%0d_in_ready", i), 64'(rdy0), 64'(tbl[i].exp_rdy));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("tbl%0d_out_valid", i), 64'(ov0), 64'(tbl[i].exp_ov));
            chk($sformatf("tbl%0d_out_data", i), od0, tbl[i].exp_od);
            chk($sformatf("tbl%0d_out_sel", i), 64'(os0), 64'(tbl[i].exp_os));
        end
        v0 = '0;

        // Fixed priority: ch1 always beats ch3.
        rst = 1'b1; ordy = 1'b1; v1 = 4'b1010;
        @(posedge clk); @(negedge clk);
        chk("fp_reset_valid", 64'(ov1), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            #1;
            chk("fp_in_ready", 64'(rdy1), 64'(4'b0010));
            @(posedge clk); @(negedge clk);
            chk("fp_out_valid", 64'(ov1), 64'd1);
            chk("fp_out_sel", 64'(os1), 64'd1);
            chk("fp_out_data", od1, C1);
        end
        v1 = '0;

        // M=3 round-robin: pointer wraps 2 -> 0.
        rst = 1'b1; ordy = 1'b1; v2 = 3'b111;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("m3_in_ready", 64'(rdy2), 64'(3'b001 << (i % 3)));
            @(posedge clk); @(negedge clk);
            chk("m3_out_sel", 64'(os2), 64'(i % 3));
            chk("m3_out_valid", 64'(ov2), 64'd1);
        end
        v2 = '0;

        // Random stimulus against the reference model.
        rand_run(0, 4, 0, 400);
        v0 = '0;
        rand_run(1, 4, 1, 200);
        v1 = '0;
        rand_run(2, 3, 0, 400);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
